ysyx_22050019_if_fetch: RTL and testbench

Instruction-fetch stage that directly feeds the IF/ID pipeline register. It owns the architectural fetch PC and issues one request at a time on a simple valid/ready instruction-memory bus. It selects the 32-bit instruction from the 64-bit response and presents pc/inst/commite to IF/ID. It honours the downstream stall and redirects from branch/jump resolution, including discarding wrong-path responses that are still in flight.

---
 rtl/ysyx_22050019_if_fetch_if.sv | 33 +++
 rtl/ysyx_22050019_if_fetch.sv | 145 ++++++++++++++
 tb/tb_ysyx_22050019_if_fetch.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050019_if_fetch_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
// One request at a time: the request phase is a valid/ready handshake,
// the response phase is a single-cycle valid pulse carrying a doubleword.
//   req_valid  : fetch request valid (master -> slave)
//   req_addr   : 8-byte aligned fetch address (master -> slave)
//   req_ready  : request accepted when valid & ready (slave -> master)
//   resp_valid : response data valid for one cycle (slave -> master)
//   resp_data  : response doubleword (slave -> master)
interface ysyx_22050019_if_fetch_if #(
    parameter int unsigned DATA_W = 64
);
    logic              req_valid;
    logic [63:0]       req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  resp_valid,
        input  resp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output resp_valid,
        output resp_data
    );
endinterface

// File: rtl/ysyx_22050019_if_fetch.sv
// Instruction-fetch stage feeding the IF/ID pipeline register.
// Owns the fetch PC, issues one request at a time on the imem bus, selects
// the 32-bit instruction from the 64-bit response and presents it to IF/ID.
// Redirects from branch/jump resolution replace the PC; any response still
// in flight for the old path is discarded.
//
// Ports:
//   clk, rst_n        : clock (rising edge), synchronous active-low reset
//   redirect_valid_i  : branch/jump taken pulse
//   redirect_pc_i     : redirect target (bits [1:0] ignored)
//   stall_i           : downstream stall, hold the presented instruction
//   imem              : instruction-memory bus (master side)
//   pc_o, inst_o      : presented PC and instruction (registered)
//   commite_o         : pc_o/inst_o valid (registered)
//   fetch_busy_o      : high while requesting or waiting for a response
//
// Optional build macro IF_FETCH_PERF_EN adds perf_fetch_cnt_o (counts
// commite_o rising edges) and perf_drop_cnt_o (counts discarded responses).
module ysyx_22050019_if_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int unsigned DATA_W   = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            redirect_valid_i,
    input  logic [63:0]                     redirect_pc_i,
    input  logic                            stall_i,
    ysyx_22050019_if_fetch_if.master        imem,
    output logic [63:0]                     pc_o,
    output logic [31:0]                     inst_o,
    output logic                            commite_o,
    output logic                            fetch_busy_o
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [63:0]                     perf_fetch_cnt_o,
    output logic [63:0]                     perf_drop_cnt_o
`endif
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StOut} state_e;

    state_e      state_q;
    logic [63:0] pc_q;
    logic [63:0] addr_q;
    logic        drop_q;
    logic [63:0] pc_out_q;
    logic [31:0] inst_q;
    logic        commite_q;
`ifdef IF_FETCH_PERF_EN
    logic [63:0] perf_fetch_q;
    logic [63:0] perf_drop_q;
`endif

    logic [63:0] redirect_tgt;
    logic [63:0] pc_hold_d;   // PC for a new request that does not advance
    logic [63:0] pc_adv_d;    // PC for the request after a consumed instruction
    logic [31:0] inst_sel;

    assign redirect_tgt = redirect_pc_i & ~64'd3;
    assign pc_hold_d    = redirect_valid_i ? redirect_tgt : pc_q;
    assign pc_adv_d     = redirect_valid_i ? redirect_tgt : pc_q + 64'd4;
    assign inst_sel     = pc_q[2] ? imem.resp_data[DATA_W-1:DATA_W/2]
                                  : imem.resp_data[DATA_W/2-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            addr_q    <= RESET_PC & ~64'd7;
            drop_q    <= 1'b0;
            pc_out_q  <= 64'd0;
            inst_q    <= 32'd0;
            commite_q <= 1'b0;
`ifdef IF_FETCH_PERF_EN
            perf_fetch_q <= 64'd0;
            perf_drop_q  <= 64'd0;
`endif
        end else begin
            if (redirect_valid_i) begin
                pc_q <= redirect_tgt;
            end
            unique case (state_q)
                StIdle: begin
                    state_q <= StReq;
                    addr_q  <= pc_hold_d & ~64'd7;
                end
                StReq: begin
                    // The pending request keeps its address; its response
                    // belongs to the old path and must be thrown away.
                    if (redirect_valid_i) begin
                        drop_q <= 1'b1;
                    end
                    if (imem.req_ready) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (imem.resp_valid) begin
                        if (drop_q || redirect_valid_i) begin
                            drop_q  <= 1'b0;
                            state_q <= StReq;
                            addr_q  <= pc_hold_d & ~64'd7;
`ifdef IF_FETCH_PERF_EN
                            perf_drop_q <= perf_drop_q + 64'd1;
`endif
                        end else begin
                            inst_q    <= inst_sel;
                            pc_out_q  <= pc_q;
                            commite_q <= 1'b1;
                            state_q   <= StOut;
`ifdef IF_FETCH_PERF_EN
                            perf_fetch_q <= perf_fetch_q + 64'd1;
`endif
                        end
                    end else if (redirect_valid_i) begin
                        drop_q <= 1'b1;
                    end
                end
                StOut: begin
                    // Redirect overrides a downstream stall.
                    if (redirect_valid_i || !stall_i) begin
                        commite_q <= 1'b0;
                        pc_out_q  <= 64'd0;
                        inst_q    <= 32'd0;
                        pc_q      <= pc_adv_d;
                        addr_q    <= pc_adv_d & ~64'd7;
                        state_q   <= StReq;
                    end
                end
            endcase
        end
    end

    assign imem.req_valid = (state_q == StReq);
    assign imem.req_addr  = addr_q;
    assign pc_o           = pc_out_q;
    assign inst_o         = inst_q;
    assign commite_o      = commite_q;
    assign fetch_busy_o   = (state_q == StReq) || (state_q == StWait);
`ifdef IF_FETCH_PERF_EN
    assign perf_fetch_cnt_o = perf_fetch_q;
    assign perf_drop_cnt_o  = perf_drop_q;
`endif

endmodule

// File: tb/tb_ysyx_22050019_if_fetch.sv
module tb_ysyx_22050019_if_fetch;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [63:0] rpc;
        logic        commite;
        logic [63:0] pc;
        logic [31:0] inst;
        logic        req_valid;
        logic [63:0] addr;
        logic        busy;
    } vec_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        stall;
    logic [63:0] pc_o;
    logic [31:0] inst_o;
    logic        commite_o;
    logic        fetch_busy_o;

    int checks = 0;
    int errors = 0;

    exp_t        exp_q[$];
    logic        last_valid = 1'b0;
    logic [63:0] last_addr  = 64'd0;
    logic [63:0] pend_addr  = 64'd0;
    int          pend_cnt   = 0;
    int          lat        = 1;
    logic        prev_commite = 1'b0;
    logic        commit_seen  = 1'b0;

    always #5 clk = ~clk;

    ysyx_22050019_if_fetch_if #(.DATA_W(64)) imem_bus ();

    ysyx_22050019_if_fetch #(
        .RESET_PC (64'h0000_0000_8000_0000),
        .DATA_W   (64)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .stall_i          (stall),
        .imem             (imem_bus),
        .pc_o             (pc_o),
        .inst_o           (inst_o),
        .commite_o        (commite_o),
        .fetch_busy_o     (fetch_busy_o)
    );

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'hAAAA0013_00000093;
        return {a[31:0] ^ 32'h5A5A_0000, ~a[31:0]};
    endfunction

    function automatic logic [31:0] exp_inst(input logic [63:0] pc);
        logic [63:0] w;
        w = mem_word({pc[63:3], 3'b000});
        return pc[2] ? w[63:32] : w[31:0];
    endfunction

    function automatic vec_t mk(logic st, logic rd, logic [63:0] rp, logic cm,
                                logic [63:0] pc, logic [31:0] in, logic rv,
                                logic [63:0] ad, logic bz);
        vec_t v;
        v.stall = st; v.redir = rd; v.rpc = rp; v.commite = cm; v.pc = pc;
        v.inst = in; v.req_valid = rv; v.addr = ad; v.busy = bz;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [63:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = exp_inst(pc);
        exp_q.push_back(e);
    endtask

    // One clock: memory model and commit monitor run #1 after the edge.
    task automatic tick();
        logic acc;
        exp_t e;
        @(posedge clk);
        #1;
        acc = last_valid && imem_bus.req_ready;
        imem_bus.resp_valid = 1'b0;
        if (acc) begin
            pend_addr = last_addr;
            pend_cnt  = lat;
        end
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_bus.resp_valid = 1'b1;
                imem_bus.resp_data  = mem_word(pend_addr);
            end
        end
        commit_seen = 1'b0;
        if (commite_o && !prev_commite) begin
            commit_seen = 1'b1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_commit got pc=%h want none", pc_o);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", pc_o, e.pc);
                check("sb_inst", {32'd0, inst_o}, {32'd0, e.inst});
            end
        end
        prev_commite = commite_o;
        last_valid   = imem_bus.req_valid;
        last_addr    = imem_bus.req_addr;
    endtask

    task automatic wait_commit(input int max);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max && !done; i++) begin
            tick();
            if (commit_seen) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL commit_timeout got=none want=commit within %0d", max);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 64'd0;
        imem_bus.req_ready = 1'b1;
        imem_bus.resp_valid = 1'b0;
        last_valid = 1'b0;
        pend_cnt = 0;
        tick();
        tick();
        pend_cnt = 0;
        rst_n = 1'b1;
    endtask

    task automatic check_queue_empty(input string name);
        check(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[16];
        imem_bus.resp_data = 64'd0;
        vecs[0]  = mk(0, 0, 0, 0, 64'd0, 32'd0, 1, 64'h8000_0000, 1);
        vecs[1]  = mk(0, 0, 0, 0, 64'd0, 32'd0, 0, 64'd0, 1);
        vecs[2]  = mk(0, 0, 0, 1, 64'h8000_0000, 32'h0000_0093, 0, 64'd0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 64'd0, 32'd0, 1, 64'h8000_0000, 1);
        vecs[4]  = mk(0, 0, 0, 0, 64'd0, 32'd0, 0, 64'd0, 1);
        vecs[5]  = mk(0, 0, 0, 1, 64'h8000_0004, 32'hAAAA_0013, 0, 64'd0, 0);
        for (int i = 6; i < 10; i++)
            vecs[i] = mk(1, 0, 0, 1, 64'h8000_0004, 32'hAAAA_0013, 0, 64'd0, 0);
        vecs[10] = mk(0, 0, 0, 0, 64'd0, 32'd0, 1, 64'h8000_0008, 1);
        vecs[11] = mk(0, 0, 0, 0, 64'd0, 32'd0, 0, 64'd0, 1);
        vecs[12] = mk(0, 0, 0, 1, 64'h8000_0008, exp_inst(64'h8000_0008), 0, 64'd0, 0);
        vecs[13] = mk(0, 1, 64'h8000_0407, 0, 64'd0, 32'd0, 1, 64'h8000_0400, 1);
        vecs[14] = mk(0, 0, 0, 0, 64'd0, 32'd0, 0, 64'd0, 1);
        vecs[15] = mk(0, 0, 0, 1, 64'h8000_0404, exp_inst(64'h8000_0404), 0, 64'd0, 0);

        // Reset state
        do_reset();
        check("rst_commite", {63'd0, commite_o}, 64'd0);
        check("rst_pc", pc_o, 64'd0);
        check("rst_inst", {32'd0, inst_o}, 64'd0);
        check("rst_req_valid", {63'd0, imem_bus.req_valid}, 64'd0);
        check("rst_busy", {63'd0, fetch_busy_o}, 64'd0);

        // Sequential fetch, stall hold, redirect with unaligned target
        lat = 1;
        push_exp(64'h8000_0000);
        push_exp(64'h8000_0004);
        push_exp(64'h8000_0008);
        push_exp(64'h8000_0404);
        for (int i = 0; i < 16; i++) begin
            stall = vecs[i].stall;
            redirect_valid = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            tick();
            check($sformatf("v%0d_commite", i), {63'd0, commite_o}, {63'd0, vecs[i].commite});
            check($sformatf("v%0d_pc", i), pc_o, vecs[i].pc);
            check($sformatf("v%0d_inst", i), {32'd0, inst_o}, {32'd0, vecs[i].inst});
            check($sformatf("v%0d_req_valid", i), {63'd0, imem_bus.req_valid},
                  {63'd0, vecs[i].req_valid});
            if (vecs[i].req_valid)
                check($sformatf("v%0d_addr", i), imem_bus.req_addr, vecs[i].addr);
            check($sformatf("v%0d_busy", i), {63'd0, fetch_busy_o}, {63'd0, vecs[i].busy});
        end
        stall = 1'b0;
        redirect_valid = 1'b0;
        check_queue_empty("table_sb_left");

        // Redirect during WAIT, response two cycles after accept
        do_reset();
        lat = 2;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        check("wr_commite_a", {63'd0, commite_o}, 64'd0);
        check("wr_req_valid_a", {63'd0, imem_bus.req_valid}, 64'd0);
        tick();
        check("wr_commite_b", {63'd0, commite_o}, 64'd0);
        check("wr_req_valid_b", {63'd0, imem_bus.req_valid}, 64'd1);
        check("wr_addr", imem_bus.req_addr, 64'h8000_0100);
        push_exp(64'h8000_0100);
        wait_commit(10);
        check_queue_empty("wr_sb_left");
        lat = 1;

        // Ready held low, redirect while request pending
        do_reset();
        imem_bus.req_ready = 1'b0;
        tick();
        check("rq_addr0", imem_bus.req_addr, 64'h8000_0000);
        for (int c = 1; c <= 5; c++) begin
            redirect_valid = (c == 2);
            redirect_pc = 64'h8000_0200;
            tick();
            check($sformatf("rq_valid_c%0d", c), {63'd0, imem_bus.req_valid}, 64'd1);
            check($sformatf("rq_addr_c%0d", c), imem_bus.req_addr, 64'h8000_0000);
        end
        redirect_valid = 1'b0;
        imem_bus.req_ready = 1'b1;
        tick();
        check("rq_accept_valid", {63'd0, imem_bus.req_valid}, 64'd0);
        tick();
        check("rq_drop_commite", {63'd0, commite_o}, 64'd0);
        check("rq_new_valid", {63'd0, imem_bus.req_valid}, 64'd1);
        check("rq_new_addr", imem_bus.req_addr, 64'h8000_0200);
        push_exp(64'h8000_0200);
        wait_commit(10);
        check_queue_empty("rq_sb_left");

        // Redirect and stall together in OUT
        do_reset();
        push_exp(64'h8000_0000);
        wait_commit(10);
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0300;
        tick();
        redirect_valid = 1'b0;
        stall = 1'b0;
        check("rs_commite", {63'd0, commite_o}, 64'd0);
        check("rs_pc", pc_o, 64'd0);
        check("rs_inst", {32'd0, inst_o}, 64'd0);
        check("rs_req_valid", {63'd0, imem_bus.req_valid}, 64'd1);
        check("rs_addr", imem_bus.req_addr, 64'h8000_0300);
        push_exp(64'h8000_0300);
        wait_commit(10);
        check_queue_empty("rs_sb_left");

        // Reset during WAIT with a stale response arriving afterwards
        do_reset();
        lat = 2;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rw_rst_valid", {63'd0, imem_bus.req_valid}, 64'd0);
        check("rw_rst_busy", {63'd0, fetch_busy_o}, 64'd0);
        tick();
        check("rw_stale_commite", {63'd0, commite_o}, 64'd0);
        check("rw_req_valid", {63'd0, imem_bus.req_valid}, 64'd1);
        check("rw_addr", imem_bus.req_addr, 64'h8000_0000);
        tick();
        check("rw_commite_after", {63'd0, commite_o}, 64'd0);
        push_exp(64'h8000_0000);
        wait_commit(10);
        check_queue_empty("rw_sb_left");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
